// File: rtl/host_loader.sv
// host_loader: framed host byte-stream front end driving the core's cmd/addr/data port and reset.
// Define HOST_LOADER_CSUM_EN to require a trailing XOR checksum byte on every non-RUN/HALT packet.
module host_loader #(
  parameter int READ_LAT  = 2,
  parameter bit BOOT_HALT = 1'b1,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  host_cmd,
  output logic [31:0] host_addr,
  output logic [31:0] host_wdata,
  input  logic [31:0] host_rdata,
  output logic        cpu_reset,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(READ_LAT + 2);
  localparam logic [7:0] ACK_B = 8'hA5;
  localparam logic [7:0] NAK_B = 8'hEE;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, EXEC, WAIT, SEND, ACK} state_t;
`ifdef HOST_LOADER_CSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = EXEC;
`endif
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, bcnt_q, bcnt_d;
  logic [7:0] ack_q, ack_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic cpu_rst_q, cpu_rst_d;
  logic rx_fire, tx_fire;
`ifdef HOST_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) csum_q <= '0;
    else csum_q <= csum_d;
  always_comb begin
    csum_d = csum_q;
    if (rx_fire) csum_d = (state_q == IDLE) ? rx_data : csum_q ^ rx_data;
  end
`endif
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign rx_ready   = state_q inside {IDLE, ADDR, DATA, CSUM};
  assign tx_valid   = state_q inside {SEND, ACK};
  assign tx_data    = (state_q == SEND) ? rbuf_q[7:0] : (state_q == ACK) ? ack_q : 8'h00;
  assign host_cmd   = (state_q inside {EXEC, WAIT}) ? op_q : 2'b00;
  assign host_addr  = addr_q;
  assign host_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign busy       = state_q != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      bcnt_q    <= '0;
      ack_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      tmo_q     <= '0;
      wcnt_q    <= '0;
      cpu_rst_q <= BOOT_HALT;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      bcnt_q    <= bcnt_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      tmo_q     <= tmo_d;
      wcnt_q    <= wcnt_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bcnt_d    = bcnt_q;
    ack_d     = ack_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    tmo_d     = '0;
    wcnt_d    = wcnt_q;
    cpu_rst_d = cpu_rst_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        op_d   = rx_data[1:0];
        bcnt_d = 2'd0;
        case (rx_data)
          8'h00, 8'h01, 8'h02, 8'h03: state_d = ADDR;
          8'h10: begin
            cpu_rst_d = 1'b0;
            ack_d     = ACK_B;
            state_d   = ACK;
          end
          8'h11: begin
            cpu_rst_d = 1'b1;
            ack_d     = ACK_B;
            state_d   = ACK;
          end
          default: begin
            ack_d   = NAK_B;
            state_d = ACK;
          end
        endcase
      end
      ADDR: if (rx_fire) begin
        addr_d = {rx_data, addr_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = op_q[0] ? DATA : TAIL;
      end
      DATA: if (rx_fire) begin
        wdata_d = {rx_data, wdata_q[31:8]};
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = TAIL;
      end
`ifdef HOST_LOADER_CSUM_EN
      CSUM: if (rx_fire) begin
        ack_d   = NAK_B;
        state_d = (rx_data == csum_q) ? EXEC : ACK;
      end
`endif
      EXEC: begin
        if (op_q[0]) begin
          ack_d   = ACK_B;
          state_d = ACK;
        end else if (READ_LAT == 0) begin
          rbuf_d  = host_rdata;
          bcnt_d  = 2'd0;
          state_d = SEND;
        end else begin
          wcnt_d  = WW'(1);
          state_d = WAIT;
        end
      end
      // host_rdata is sampled on the last of the READ_LAT+1 cycles the read command is held
      WAIT: begin
        if (wcnt_q == WW'(READ_LAT)) begin
          rbuf_d  = host_rdata;
          bcnt_d  = 2'd0;
          state_d = SEND;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      SEND: if (tx_fire) begin
        rbuf_d = {8'h00, rbuf_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = IDLE;
      end
      ACK: if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q inside {ADDR, DATA, CSUM} && !rx_fire) begin
      if (tmo_q == TW'(TIMEOUT - 1)) state_d = IDLE;
      else tmo_d = tmo_q + TW'(1);
    end
  end
endmodule
